// File: rtl/bip_data_if.sv
// Data-port bus between the BIP2 core (master) and its data responder (slave).
// Reads are combinational and writes are strobed; the bus never stalls.
interface bip_data_if #(
    parameter int OPERAND_ADDRESS_WIDTH  = 11,
    parameter int INSTRUCTION_DATA_WIDTH = 16
) ();
    logic [OPERAND_ADDRESS_WIDTH-1:0]  data_address_in;
    logic [INSTRUCTION_DATA_WIDTH-1:0] data_in;
    logic                              data_wr_in;
    logic [INSTRUCTION_DATA_WIDTH-1:0] data_out;

    // Handshake: none. data_wr_in=1 commits data_in on the next rising edge,
    // data_out is always valid for the current data_address_in.
    modport master (
        output data_address_in, data_in, data_wr_in,
        input  data_out
    );
    modport slave (
        input  data_address_in, data_in, data_wr_in,
        output data_out
    );
endinterface

// File: rtl/bip_data_responder.sv
// Data-memory responder for the BIP2 core: data RAM below IO_BASE, plus an I/O block
// with an output port, a synchronized input port and a compare/match timer.
module bip_data_responder #(
    parameter int OPERAND_ADDRESS_WIDTH  = 11,
    parameter int INSTRUCTION_DATA_WIDTH = 16,
    parameter int IO_BASE                = 'h400,
    parameter int PRESCALE               = 1
) (
    input  logic                              clock_in,
    input  logic                              reset_in,
    bip_data_if.slave                         bus,
    input  logic [INSTRUCTION_DATA_WIDTH-1:0] port_in,
    output logic [INSTRUCTION_DATA_WIDTH-1:0] port_out,
    output logic                              timer_flag_out
);
    localparam int AW     = OPERAND_ADDRESS_WIDTH;
    localparam int W      = INSTRUCTION_DATA_WIDTH;
    localparam int RAM_AW = (IO_BASE > 1) ? $clog2(IO_BASE) : 1;
    localparam int PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [AW-1:0]   IO_BASE_A  = AW'(IO_BASE);
    localparam logic [AW-1:0]   OFF_PORT   = AW'(0);
    localparam logic [AW-1:0]   OFF_PIN    = AW'(1);
    localparam logic [AW-1:0]   OFF_TCOUNT = AW'(2);
    localparam logic [AW-1:0]   OFF_TCMP   = AW'(3);
    localparam logic [AW-1:0]   OFF_TCTRL  = AW'(4);
    localparam logic [PS_W-1:0] PS_LAST    = PS_W'(PRESCALE - 1);

    logic [W-1:0]      ram [0:IO_BASE-1];
    logic [W-1:0]      sync_1, sync_2;
    logic [W-1:0]      t_count, t_cmp;
    logic              t_enable, t_flag;
    logic [PS_W-1:0]   prescaler;

    logic              io_sel;
    logic [AW-1:0]     io_offset;
    logic [RAM_AW-1:0] ram_index;
    logic              wr_port, wr_tcount, wr_tcmp, wr_tctrl;
    logic              tick, match;

    assign io_sel    = (bus.data_address_in >= IO_BASE_A);
    assign io_offset = bus.data_address_in - IO_BASE_A;
    assign ram_index = bus.data_address_in[RAM_AW-1:0];

    assign wr_port   = bus.data_wr_in && io_sel && (io_offset == OFF_PORT);
    assign wr_tcount = bus.data_wr_in && io_sel && (io_offset == OFF_TCOUNT);
    assign wr_tcmp   = bus.data_wr_in && io_sel && (io_offset == OFF_TCMP);
    assign wr_tctrl  = bus.data_wr_in && io_sel && (io_offset == OFF_TCTRL);

    assign tick  = t_enable && (prescaler == PS_LAST);
    assign match = (t_count == t_cmp);

    always_ff @(posedge clock_in) begin
        if (!reset_in && bus.data_wr_in && !io_sel) begin
            ram[ram_index] <= bus.data_in;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            port_out  <= '0;
            sync_1    <= '0;
            sync_2    <= '0;
            t_count   <= '0;
            t_cmp     <= '0;
            t_enable  <= 1'b0;
            t_flag    <= 1'b0;
            prescaler <= '0;
        end else begin
            sync_1 <= port_in;
            sync_2 <= sync_1;

            if (wr_port) port_out <= bus.data_in;
            if (wr_tcmp) t_cmp <= bus.data_in;
            if (wr_tctrl) t_enable <= bus.data_in[0];

            // A CPU load of the count overrides the tick and suppresses its flag.
            if (wr_tcount) begin
                t_count   <= bus.data_in;
                prescaler <= '0;
            end else begin
                if (tick) t_count <= match ? '0 : t_count + 1'b1;
                if (t_enable) prescaler <= tick ? '0 : prescaler + 1'b1;
            end

            // A match on this edge beats a simultaneous write-1-to-clear.
            if (tick && match && !wr_tcount) t_flag <= 1'b1;
            else if (wr_tctrl && bus.data_in[1]) t_flag <= 1'b0;
        end
    end

    always_comb begin
        bus.data_out = '0;
        if (!io_sel) begin
            bus.data_out = ram[ram_index];
        end else begin
            case (io_offset)
                OFF_PORT:   bus.data_out = port_out;
                OFF_PIN:    bus.data_out = sync_2;
                OFF_TCOUNT: bus.data_out = t_count;
                OFF_TCMP:   bus.data_out = t_cmp;
                OFF_TCTRL:  bus.data_out = {{(W-2){1'b0}}, t_flag, t_enable};
                default:    bus.data_out = '0;
            endcase
        end
    end

    assign timer_flag_out = t_flag;
endmodule

// File: tb/tb_bip_data_responder.sv
// Bench for bip_data_responder: behavioural memory-map model checked every cycle,
// plus directed accesses with literal expectations.
module tb_bip_data_responder;
    localparam int AW = 11;
    localparam int W = 16;
    localparam int IO_BASE = 'h400;
    localparam int PRESCALE = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [W-1:0] port_in = '0;
    logic [W-1:0] port_out;
    logic timer_flag;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    bip_data_if #(.OPERAND_ADDRESS_WIDTH(AW), .INSTRUCTION_DATA_WIDTH(W)) bus ();

    bip_data_responder #(
        .OPERAND_ADDRESS_WIDTH(AW), .INSTRUCTION_DATA_WIDTH(W),
        .IO_BASE(IO_BASE), .PRESCALE(PRESCALE)
    ) dut (
        .clock_in(clk), .reset_in(rst), .bus(bus),
        .port_in(port_in), .port_out(port_out), .timer_flag_out(timer_flag)
    );

    // clock / reset
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_ram [int];
    logic [W-1:0] pin_hist[$];
    logic [W-1:0] m_port, m_count, m_cmp;
    bit m_en, m_flag;
    int m_ps;

    initial begin
        pin_hist = '{16'h0, 16'h0};
        m_port = '0; m_count = '0; m_cmp = '0; m_en = 0; m_flag = 0; m_ps = 0;
    end

    always @(posedge clk) begin
        int off;
        bit is_tick, load_cnt;
        if (rst) begin
            m_port = '0; m_count = '0; m_cmp = '0; m_en = 0; m_flag = 0; m_ps = 0;
            pin_hist = '{16'h0, 16'h0};
        end else begin
            off = int'(bus.data_address_in) - IO_BASE;
            pin_hist.push_back(port_in);
            void'(pin_hist.pop_front());
            is_tick = m_en && (m_ps == PRESCALE - 1);
            load_cnt = bus.data_wr_in && off == 2;
            if (bus.data_wr_in && off < 0) m_ram[int'(bus.data_address_in)] = bus.data_in;
            if (load_cnt) begin
                m_count = bus.data_in;
                m_ps = 0;
            end else begin
                if (is_tick) begin
                    if (m_count == m_cmp) begin
                        m_count = '0;
                        m_flag = 1;
                    end else begin
                        m_count = m_count + 16'd1;
                    end
                end
                if (m_en) m_ps = (m_ps + 1) % PRESCALE;
            end
            if (bus.data_wr_in && off == 0) m_port = bus.data_in;
            if (bus.data_wr_in && off == 3) m_cmp = bus.data_in;
            if (bus.data_wr_in && off == 4) begin
                if (bus.data_in[1] && !(is_tick && !load_cnt && m_flag && m_count == 0))
                    m_flag = 0;
                m_en = bus.data_in[0];
            end
        end
    end

    function automatic bit model_read(input logic [AW-1:0] a, output logic [W-1:0] v);
        int off = int'(a) - IO_BASE;
        v = '0;
        if (off < 0) begin
            if (!m_ram.exists(int'(a))) return 0;
            v = m_ram[int'(a)];
            return 1;
        end
        case (off)
            0: v = m_port;
            1: v = pin_hist[0];
            2: v = m_count;
            3: v = m_cmp;
            4: v = {14'h0, m_flag, m_en};
            default: v = '0;
        endcase
        return 1;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] v;
        if (started && !rst) begin
            if (model_read(bus.data_address_in, v)) check("model_data_out", 32'(bus.data_out), 32'(v));
            check("model_port_out", 32'(port_out), 32'(m_port));
            check("model_flag", 32'(timer_flag), 32'(m_flag));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [W-1:0] d);
        bus.data_address_in = a;
        bus.data_in = d;
        bus.data_wr_in = 1'b1;
        step();
        bus.data_wr_in = 1'b0;
    endtask

    task automatic peek(input string name, input logic [AW-1:0] a, input logic [W-1:0] exp);
        bus.data_address_in = a;
        bus.data_wr_in = 1'b0;
        #1;
        check(name, 32'(bus.data_out), 32'(exp));
    endtask

    localparam logic [AW-1:0] A_PORT = AW'(IO_BASE);
    localparam logic [AW-1:0] A_PIN = AW'(IO_BASE + 1);
    localparam logic [AW-1:0] A_CNT = AW'(IO_BASE + 2);
    localparam logic [AW-1:0] A_CMP = AW'(IO_BASE + 3);
    localparam logic [AW-1:0] A_CTRL = AW'(IO_BASE + 4);
    localparam logic [AW-1:0] A_BAD = AW'(IO_BASE + 7);

    initial begin
        bus.data_address_in = '0;
        bus.data_in = '0;
        bus.data_wr_in = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        started = 1'b1;

        check("reset_port_out", 32'(port_out), 32'h0);
        check("reset_flag", 32'(timer_flag), 32'h0);
        peek("reset_count", A_CNT, 16'h0);
        peek("reset_cmp", A_CMP, 16'h0);
        peek("reset_ctrl", A_CTRL, 16'h0);

        // RAM, including the last RAM word and a same-cycle read of old data
        write(11'd5, 16'h1234);
        write(11'h3FF, 16'hBEEF);
        peek("ram_5", 11'd5, 16'h1234);
        peek("ram_3ff", 11'h3FF, 16'hBEEF);
        bus.data_address_in = 11'd5;
        bus.data_in = 16'h5555;
        bus.data_wr_in = 1'b1;
        #1;
        check("ram_old_value", 32'(bus.data_out), 32'h1234);
        step();
        bus.data_wr_in = 1'b0;
        peek("ram_new_value", 11'd5, 16'h5555);

        // output port
        write(A_PORT, 16'h00A5);
        check("port_out_pin", 32'(port_out), 32'h00A5);
        peek("port_out_read", A_PORT, 16'h00A5);

        // input synchronizer
        peek("pin_before", A_PIN, 16'h0);
        port_in = 16'h0F0F;
        step();
        peek("pin_1_edge", A_PIN, 16'h0);
        step();
        peek("pin_2_edges", A_PIN, 16'h0F0F);

        // timer counting to match
        write(A_CMP, 16'd3);
        write(A_CTRL, 16'h1);
        peek("cnt_0", A_CNT, 16'd0);
        step(); peek("cnt_1", A_CNT, 16'd1);
        step(); peek("cnt_2", A_CNT, 16'd2);
        step(); peek("cnt_3", A_CNT, 16'd3);
        check("flag_before_match", 32'(timer_flag), 32'h0);
        step(); peek("cnt_wrap_0", A_CNT, 16'd0);
        check("flag_on_match", 32'(timer_flag), 32'h1);
        step(); peek("cnt_after", A_CNT, 16'd1);
        check("flag_sticky", 32'(timer_flag), 32'h1);
        peek("ctrl_flag_en", A_CTRL, 16'h3);

        // clear colliding with a match: set wins
        step(); step();
        peek("cnt_at_match", A_CNT, 16'd3);
        write(A_CTRL, 16'h3);
        check("set_beats_clear", 32'(timer_flag), 32'h1);
        peek("cnt_after_match", A_CNT, 16'd0);
        write(A_CTRL, 16'h3);
        check("flag_cleared", 32'(timer_flag), 32'h0);
        peek("cnt_after_clear", A_CNT, 16'd1);

        // load in a tick cycle: no increment, no flag even when loaded value matches
        write(A_CNT, 16'd3);
        peek("cnt_loaded", A_CNT, 16'd3);
        check("load_no_flag", 32'(timer_flag), 32'h0);
        step();
        peek("cnt_match_after_load", A_CNT, 16'd0);
        check("flag_after_load", 32'(timer_flag), 32'h1);
        write(A_CTRL, 16'h3);

        // modulo wrap of the count
        write(A_CNT, 16'hFFFF);
        peek("cnt_ffff", A_CNT, 16'hFFFF);
        step();
        peek("cnt_wrap_mod", A_CNT, 16'h0000);

        // unmapped I/O offset
        write(A_BAD, 16'hFFFF);
        peek("bad_read", A_BAD, 16'h0);
        check("bad_port_unchanged", 32'(port_out), 32'h00A5);
        peek("bad_cmp_unchanged", A_CMP, 16'd3);

        // reset while counting
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        peek("rst_count", A_CNT, 16'h0);
        check("rst_flag", 32'(timer_flag), 32'h0);
        check("rst_port_out", 32'(port_out), 32'h0);
        peek("rst_ctrl", A_CTRL, 16'h0);
        peek("rst_pin", A_PIN, 16'h0);
        step(); step();
        peek("rst_pin_resync", A_PIN, 16'h0F0F);
        peek("rst_count_frozen", A_CNT, 16'h0);
        peek("ram_kept", 11'h3FF, 16'hBEEF);

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
